// File: rtl/calc_cmd_driver.sv
// Initiator for the 4-bit calculator: buffers op commands, issues them one at a
// time with a st pulse, checks the registered result and returns a response.
module calc_cmd_driver #(
  parameter int CMD_DEPTH = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic             calc_st,
  output logic [1:0]       calc_op,
  output logic [3:0]       calc_a,
  output logic [3:0]       calc_b,
  input  logic [3:0]       calc_result,
  input  logic             calc_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_op,
  output logic [3:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic             rsp_dz,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(CMD_DEPTH);

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  cmd_t          mem [CMD_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_nxt;
  logic          push, pop, head_dz;
  logic [1:0]    h_op;
  logic [3:0]    h_a, h_b;
  logic [7:0]    prod;
  logic [4:0]    expct;

  assign push    = cmd_valid && cmd_ready;
  assign pop     = (state == IDLE) && (count != '0);
  assign head    = mem[rptr];
  assign head_dz = (head.op == 2'b11) && (head.b == 4'd0);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // cmd_ready is a registered not-full flag, so it never depends on the pop path
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count     <= count_nxt;
      cmd_ready <= (count_nxt != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
  end

  // Reference model of the calculator's 5-bit {carry,result}
  assign prod = {4'b0, h_a} * {4'b0, h_b};

  always_comb begin
    expct = '0;
    case (h_op)
      2'b00:   expct = {1'b0, h_a} + {1'b0, h_b};
      2'b01:   expct = {1'b0, h_a} - {1'b0, h_b};
      2'b10:   expct = prod[4:0];
      default: expct = {1'b0, h_a / h_b};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      h_op       <= '0;
      h_a        <= '0;
      h_b        <= '0;
      calc_st    <= 1'b0;
      calc_op    <= '0;
      calc_a     <= '0;
      calc_b     <= '0;
      rsp_valid  <= 1'b0;
      rsp_op     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_dz     <= 1'b0;
      pass_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          h_op   <= head.op;
          h_a    <= head.a;
          h_b    <= head.b;
          rsp_op <= head.op;
          if (head_dz) begin
            // divide-by-zero is answered locally; the calculator never sees it
            rsp_dz     <= 1'b1;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            calc_st <= 1'b1;
            calc_op <= head.op;
            calc_a  <= head.a;
            calc_b  <= head.b;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          calc_st <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          rsp_result <= calc_result;
          rsp_carry  <= calc_carry;
          rsp_dz     <= 1'b0;
          rsp_valid  <= 1'b1;
          if ({calc_carry, calc_result} != expct) begin
            rsp_err <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end else begin
            rsp_err <= 1'b0;
            if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
          end
          state <= RESP;
        end
        default: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_cmd_driver.sv
// Directed bench for calc_cmd_driver with a behavioural 4-bit calculator that
// can be told to corrupt its answer.
module tb_calc_cmd_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic       calc_st;
  logic [1:0] calc_op;
  logic [3:0] calc_a, calc_b;
  logic [3:0] calc_result = '0;
  logic       calc_carry = 1'b0;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [1:0] rsp_op;
  logic [3:0] rsp_result;
  logic       rsp_carry, rsp_err, rsp_dz;
  logic [7:0] pass_cnt, err_cnt;

  int n_cmp = 0, n_bad = 0, st_cnt = 0, st0;
  bit corrupt = 1'b0;
  logic [1:0] r_op;
  logic [3:0] r_res;
  logic       r_c, r_err, r_dz;
  logic [1:0] q_op [5];
  logic [4:0] q_v  [5];

  calc_cmd_driver #(.CMD_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .calc_st(calc_st), .calc_op(calc_op), .calc_a(calc_a), .calc_b(calc_b),
    .calc_result(calc_result), .calc_carry(calc_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_op(rsp_op), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .rsp_err(rsp_err), .rsp_dz(rsp_dz),
    .pass_cnt(pass_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] calc_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = {4'b0, a} * {4'b0, b};
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return p[4:0];
      default: return (b == 4'd0) ? 5'd0 : {1'b0, a / b};
    endcase
  endfunction

  // Calculator registers its answer on the st edge
  always @(posedge clk) begin
    if (calc_st === 1'b1) begin
      st_cnt++;
      {calc_carry, calc_result} <= calc_f(calc_op, calc_a, calc_b) + (corrupt ? 5'd1 : 5'd0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int t;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("push_acc", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp();
    int t;
    t = 0;
    while (rsp_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("rsp_seen", rsp_valid, 1);
    r_op = rsp_op; r_res = rsp_result; r_c = rsp_carry; r_err = rsp_err; r_dz = rsp_dz;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // add 9+8 with exact cycle timing, starting from freshly reset counters
  task automatic scen_basic();
    chk("b_ready", cmd_ready, 1);
    st0 = st_cnt;
    cmd_op = 2'b00; cmd_a = 4'd9; cmd_b = 4'd8; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b_st_early", calc_st, 0);
    @(negedge clk);
    chk("b_st", calc_st, 1);
    chk("b_issue", {calc_op, calc_a, calc_b}, {2'b00, 4'd9, 4'd8});
    @(negedge clk);
    chk("b_st_off", calc_st, 0);
    chk("b_hold", {calc_op, calc_a, calc_b}, {2'b00, 4'd9, 4'd8});
    chk("b_vld_early", rsp_valid, 0);
    @(negedge clk);
    chk("b_vld", rsp_valid, 1);
    chk("b_rsp", {rsp_op, rsp_carry, rsp_result, rsp_err, rsp_dz}, {2'b00, 1'b1, 4'd1, 1'b0, 1'b0});
    chk("b_cnt", {pass_cnt, err_cnt}, {8'd1, 8'd0});
    chk("b_one_st", st_cnt - st0, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("b_vld_drop", rsp_valid, 0);
  endtask

  initial begin
    #12;
    chk("rst_outs", {calc_st, calc_op, calc_a, calc_b, rsp_valid, rsp_op, rsp_result,
                     rsp_carry, rsp_err, rsp_dz, cmd_ready}, 0);
    chk("rst_cnt", {pass_cnt, err_cnt}, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    scen_basic();

    push(2'b01, 4'd3, 4'd5);  get_rsp();
    chk("sub", {r_op, r_c, r_res, r_err}, {2'b01, 1'b1, 4'd14, 1'b0});
    push(2'b10, 4'd7, 4'd7);  get_rsp();
    chk("mul", {r_op, r_c, r_res, r_err}, {2'b10, 1'b1, 4'd1, 1'b0});
    push(2'b11, 4'd13, 4'd4); get_rsp();
    chk("div", {r_op, r_c, r_res, r_err}, {2'b11, 1'b0, 4'd3, 1'b0});
    chk("cnt4", {pass_cnt, err_cnt}, {8'd4, 8'd0});

    st0 = st_cnt;
    push(2'b11, 4'd6, 4'd0);  get_rsp();
    chk("dz_rsp", {r_op, r_dz, r_c, r_res, r_err}, {2'b11, 1'b1, 1'b0, 4'd0, 1'b0});
    chk("dz_no_st", st_cnt - st0, 0);
    chk("dz_cnt", {pass_cnt, err_cnt}, {8'd4, 8'd0});

    corrupt = 1'b1;
    push(2'b00, 4'd2, 4'd2);  get_rsp();
    corrupt = 1'b0;
    chk("bad_rsp", {r_c, r_res, r_err, r_dz}, {1'b0, 4'd5, 1'b1, 1'b0});
    chk("bad_cnt", {pass_cnt, err_cnt}, {8'd4, 8'd1});

    // Fill the FIFO behind a stalled response
    q_op[0] = 2'b00; q_v[0] = 5'd3;
    q_op[1] = 2'b01; q_v[1] = 5'd5;
    q_op[2] = 2'b10; q_v[2] = 5'd15;
    q_op[3] = 2'b11; q_v[3] = 5'd4;
    q_op[4] = 2'b00; q_v[4] = 5'd30;
    push(2'b00, 4'd1, 4'd2);
    push(2'b01, 4'd8, 4'd3);
    push(2'b10, 4'd3, 4'd5);
    push(2'b11, 4'd9, 4'd2);
    push(2'b00, 4'd15, 4'd15);
    chk("full_ready", cmd_ready, 0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_rsp", {rsp_valid, rsp_op, rsp_carry, rsp_result}, {1'b1, 2'b00, 5'd3});
    end
    for (int i = 0; i < 5; i++) begin
      get_rsp();
      chk($sformatf("drain%0d", i), {r_op, r_c, r_res, r_err}, {q_op[i], q_v[i], 1'b0});
    end
    chk("drain_ready", cmd_ready, 1);
    chk("drain_cnt", {pass_cnt, err_cnt}, {8'd9, 8'd1});

    // Reset while the first command waits for its result, second still queued
    push(2'b00, 4'd1, 4'd1);
    push(2'b00, 4'd2, 4'd3);
    chk("w_st", calc_st, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("w_rst_out", {calc_st, rsp_valid, cmd_ready}, 0);
    chk("w_rst_cnt", {pass_cnt, err_cnt}, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    st0 = st_cnt;
    repeat (6) @(negedge clk);
    chk("w_empty_st", st_cnt - st0, 0);
    chk("w_empty_vld", rsp_valid, 0);
    scen_basic();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_cmd_driver.md
Name: calc_cmd_driver

Overview:
- Initiator side of the 4-bit calculator's st/op/a/b/result/carry interface.
- Accepts operation commands over a valid/ready stream and buffers them in a small FIFO.
- Issues each command to the calculator as a one-cycle st pulse, captures the registered result/carry, and checks them against an internal reference model.
- Returns each response, with pass/fail and divide-by-zero flags, over a second valid/ready stream. Sits between a test/control sequencer and the calculator instance.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of two, >=2).
- CNT_W, 8, width of the pass and error counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept a command
- cmd_op  in  2  00 add, 01 sub, 10 mul, 11 div
- cmd_a  in  4  operand a
- cmd_b  in  4  operand b
- calc_st  out  1  start strobe to calculator
- calc_op  out  2  op to calculator
- calc_a  out  4  operand a to calculator
- calc_b  out  4  operand b to calculator
- calc_result  in  4  calculator registered result
- calc_carry  in  1  calculator registered carry
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_op  out  2  op of this response
- rsp_result  out  4  captured result
- rsp_carry  out  1  captured carry
- rsp_err  out  1  captured {carry,result} differs from expected
- rsp_dz  out  1  command was divide-by-zero, not issued
- pass_cnt  out  CNT_W  checked responses that matched
- err_cnt  out  CNT_W  checked responses that mismatched

Behaviour:
- Reset (rst low, async) values:
  - All outputs 0; cmd_ready 1 once reset deasserts.
  - FIFO emptied, FSM to IDLE.
  - Reset mid-operation drops calc_st to 0 immediately and discards any in-flight command and response.
- Command FIFO:
  - Push on clk edge when cmd_valid && cmd_ready.
  - cmd_ready = !full, a registered count compare with no combinational path from the pop side. A push while full is impossible.
  - Push and pop on the same edge leave the count unchanged.
  - Pointers wrap modulo CMD_DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO is non-empty, pop the head into the op/a/b holding registers.
    - If op==11 and b==0: go to RESP with rsp_dz=1, rsp_result=0, rsp_carry=0, rsp_err=0. Counters do not change and calc_st never pulses.
    - Otherwise go to ISSUE.
  - ISSUE: calc_st=1 for exactly this one cycle, with calc_op/a/b driven from the holding registers. The calculator registers its result at the end of this cycle. Always go to WAIT.
  - WAIT: calc_st=0. At the end of this cycle:
    - Sample calc_result and calc_carry.
    - Compare against the expected value and set rsp_err.
    - Increment pass_cnt or err_cnt (saturating at all-ones).
    - Go to RESP.
  - RESP: rsp_valid=1 with all rsp_* fields stable. On rsp_valid && rsp_ready, go to IDLE. rsp_valid is not held high once IDLE is re-entered.
- calc_op/a/b hold their last issued values outside ISSUE. calc_st is 0 outside ISSUE.
- Latency: the command is popped at edge N; calc_st is high between edges N and N+1; the result is captured at edge N+2; rsp_valid is high from edge N+2. Back-to-back commands with rsp_ready held 1 issue once every 4 cycles.
- Expected model, 5-bit {carry,result}:
  - add: a+b
  - sub: ({1'b0,a} - {1'b0,b}) mod 32, so carry=1 when a<b
  - mul: low 5 bits of the 8-bit product
  - div: {1'b0, a/b}
- rsp_op always equals the command's op, including for dz responses.
- Ordering: responses leave in command arrival order. There is only one command in flight at a time.

Test Plan:
- After reset: all outputs 0, cmd_ready=1. Push add a=9 b=8 -> calc_st pulses one cycle with op=00 a=9 b=8; rsp_valid 2 edges after pop with result=1, carry=1, err=0; pass_cnt=1.
- Sub a=3 b=5 -> rsp_result=14, rsp_carry=1, err=0. Mul a=7 b=7 (49) -> result=1, carry=1. Div a=13 b=4 -> result=3, carry=0.
- Div a=6 b=0 -> calc_st never asserts; rsp_dz=1, result=0, err=0; pass_cnt and err_cnt unchanged.
- Calculator model forced to return result+1 on add 2+2 -> rsp_result=5, rsp_err=1, err_cnt increments by 1.
- Hold rsp_ready=0 and push 5 commands with CMD_DEPTH=4 -> cmd_ready falls after the FIFO fills; rsp fields stay stable. Release rsp_ready -> all responses emerge in order and none are lost.
- Assert rst during WAIT -> calc_st=0 and rsp_valid=0 immediately, FIFO empty, counters 0. The next command after release behaves exactly as in the first scenario.
